apb_master_bridge: RTL and testbench

// - Converts a simple single-request bus-side interface (CPU/system bus) into APB3 transfers.
// - Drives four APB slaves with decoded PSELx, e.g. the 4 KB word RAM at slot 0.
// - Sits directly upstream of every APB peripheral.
// - Provides address decode, PRDATA/PREADY return muxing and a PREADY timeout.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_addr_decoder.sv | 26 ++
 rtl/apb_master_bridge.sv | 171 +++++++++++++++++
 tb/tb_apb_master_bridge.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge and its address decoder.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int          APB_SLV_NUM      = 4;
    localparam int          APB_SLOT_BITS    = 4;
    localparam logic [31:0] APB_DEFAULT_BASE = 32'h1000_0000;

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps the upper address bits to an APB slot: 4 KB slots starting at APB_BASE.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter logic [31:0] APB_BASE = APB_DEFAULT_BASE
) (
    input  logic [31:12]           addr_hi,
    output logic                   hit,
    output logic [1:0]             slot,
    output logic [APB_SLV_NUM-1:0] psel_onehot
);

    logic [APB_SLOT_BITS-1:0] slot_field;

    assign slot_field = addr_hi[15:12];
    assign hit        = (addr_hi[31:16] == APB_BASE[31:16]) &&
                        (slot_field < APB_SLOT_BITS'(APB_SLV_NUM));
    assign slot       = slot_field[1:0];

    generate
        for (genvar gi = 0; gi < APB_SLV_NUM; gi++) begin : g_psel
            assign psel_onehot[gi] = hit && (slot == 2'(gi));
        end
    endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// Single-request bus to APB3 bridge: decode, SETUP/ACCESS sequencing, return mux, PREADY timeout.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter logic [31:0] APB_BASE    = APB_DEFAULT_BASE,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        transfer,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic [11:0] PADDR,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic        PENABLE,
    output logic        PSEL0,
    output logic        PSEL1,
    output logic        PSEL2,
    output logic        PSEL3,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic        PREADY0,
    input  logic        PREADY1,
    input  logic        PREADY2,
    input  logic        PREADY3
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    apb_state_e             state_reg, state_next;
    logic [APB_SLV_NUM-1:0] psel_reg, psel_next;
    logic [1:0]             slot_reg, slot_next;
    logic [11:0]            paddr_reg, paddr_next;
    logic                   pwrite_reg, pwrite_next;
    logic [31:0]            pwdata_reg, pwdata_next;
    logic [CNT_W-1:0]       wait_cnt_reg, wait_cnt_next;
    logic [31:0]            rdata_reg, rdata_next;
    logic                   ready_reg, ready_next;
    logic                   err_reg, err_next;

    logic                   dec_hit;
    logic [1:0]             dec_slot;
    logic [APB_SLV_NUM-1:0] dec_psel;

    logic [31:0]            prdata_arr [APB_SLV_NUM];
    logic [APB_SLV_NUM-1:0] pready_vec;
    logic [31:0]            sel_prdata;
    logic                   sel_pready;
    logic [APB_SLV_NUM-1:0] psel_vec;

    apb_addr_decoder #(
        .APB_BASE (APB_BASE)
    ) u_decoder (
        .addr_hi     (addr[31:12]),
        .hit         (dec_hit),
        .slot        (dec_slot),
        .psel_onehot (dec_psel)
    );

    // Return path follows only the latched slot, so other slaves' PREADY never leaks in.
    assign prdata_arr[0] = PRDATA0;
    assign prdata_arr[1] = PRDATA1;
    assign prdata_arr[2] = PRDATA2;
    assign prdata_arr[3] = PRDATA3;
    assign pready_vec    = {PREADY3, PREADY2, PREADY1, PREADY0};
    assign sel_prdata    = prdata_arr[slot_reg];
    assign sel_pready    = pready_vec[slot_reg];

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_reg    <= IDLE;
            psel_reg     <= '0;
            slot_reg     <= '0;
            paddr_reg    <= '0;
            pwrite_reg   <= 1'b0;
            pwdata_reg   <= '0;
            wait_cnt_reg <= '0;
            rdata_reg    <= '0;
            ready_reg    <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            psel_reg     <= psel_next;
            slot_reg     <= slot_next;
            paddr_reg    <= paddr_next;
            pwrite_reg   <= pwrite_next;
            pwdata_reg   <= pwdata_next;
            wait_cnt_reg <= wait_cnt_next;
            rdata_reg    <= rdata_next;
            ready_reg    <= ready_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        psel_next     = psel_reg;
        slot_next     = slot_reg;
        paddr_next    = paddr_reg;
        pwrite_next   = pwrite_reg;
        pwdata_next   = pwdata_reg;
        wait_cnt_next = wait_cnt_reg;
        rdata_next    = rdata_reg;
        ready_next    = 1'b0;
        err_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (transfer) begin
                    paddr_next  = addr[11:0];
                    pwrite_next = write;
                    pwdata_next = wdata;
                    if (dec_hit) begin
                        psel_next     = dec_psel;
                        slot_next     = dec_slot;
                        wait_cnt_next = '0;
                        state_next    = SETUP;
                    end else begin
                        // Decode miss completes immediately without touching the APB.
                        ready_next = 1'b1;
                        err_next   = 1'b1;
                        rdata_next = '0;
                    end
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (sel_pready) begin
                    ready_next = 1'b1;
                    rdata_next = pwrite_reg ? 32'd0 : sel_prdata;
                    state_next = IDLE;
                end else if (wait_cnt_reg == CNT_LAST) begin
                    ready_next = 1'b1;
                    err_next   = 1'b1;
                    rdata_next = '0;
                    state_next = IDLE;
                end else if (wait_cnt_reg != CNT_MAX) begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign psel_vec = (state_reg == IDLE) ? '0 : psel_reg;
    assign PSEL0    = psel_vec[0];
    assign PSEL1    = psel_vec[1];
    assign PSEL2    = psel_vec[2];
    assign PSEL3    = psel_vec[3];
    assign PENABLE  = (state_reg == ACCESS);
    assign PADDR    = paddr_reg;
    assign PWRITE   = pwrite_reg;
    assign PWDATA   = pwdata_reg;
    assign rdata    = rdata_reg;
    assign ready    = ready_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench: RAM slave (registered PREADY), programmable-wait slave and two fixed slaves.
module tb_apb_master_bridge;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        transfer, write;
    logic [31:0] addr, wdata, rdata;
    logic        ready, err;
    logic [11:0] PADDR;
    logic        PWRITE, PENABLE;
    logic [31:0] PWDATA;
    logic        PSEL0, PSEL1, PSEL2, PSEL3;
    logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
    logic        PREADY0, PREADY1, PREADY2, PREADY3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 PCLK = ~PCLK;

    apb_master_bridge dut (
        .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE),
        .PSEL0(PSEL0), .PSEL1(PSEL1), .PSEL2(PSEL2), .PSEL3(PSEL3),
        .PRDATA0(PRDATA0), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PRDATA3(PRDATA3),
        .PREADY0(PREADY0), .PREADY1(PREADY1), .PREADY2(PREADY2), .PREADY3(PREADY3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Slot 0: word RAM whose PREADY is a registered copy of PSEL&PENABLE (re-asserts once after completion)
    logic [31:0] ram0 [1024];
    always @(posedge PCLK) begin
        if (PRESET) PREADY0 <= 1'b0;
        else        PREADY0 <= PSEL0 & PENABLE;
        if (PSEL0 && PENABLE && PREADY0 && PWRITE) ram0[PADDR[11:2]] <= PWDATA;
    end
    assign PRDATA0 = ram0[PADDR[11:2]];

    // Slot 1: register file with wait1 wait states in ACCESS; PREADY is not gated by PSEL
    logic [31:0] mem1 [16];
    int wait1 = 0;
    int cnt1;
    always @(posedge PCLK) begin
        if (PRESET || !(PSEL1 && PENABLE)) cnt1 <= 0;
        else                               cnt1 <= cnt1 + 1;
        if (PSEL1 && PENABLE && PREADY1 && PWRITE) mem1[PADDR[5:2]] <= PWDATA;
    end
    assign PREADY1 = (cnt1 >= wait1);
    assign PRDATA1 = mem1[PADDR[5:2]];

    // Slots 2/3: always ready, read-only pattern
    assign PREADY2 = 1'b1;
    assign PREADY3 = 1'b1;
    assign PRDATA2 = 32'hA200_0000 | {20'd0, PADDR};
    assign PRDATA3 = 32'hA300_0000 | {20'd0, PADDR};

    // Reference model state
    logic [31:0] ram0_m [1024];
    logic [31:0] mem1_m [16];
    logic [3:0]  exp_psel  = 4'b0;
    logic [11:0] exp_paddr = 12'd0;
    logic        exp_pwrite = 1'b0;
    logic [31:0] exp_pwdata = 32'd0;

    // Protocol monitor
    logic [3:0]  psel;
    logic [3:0]  prev_psel = 4'b0;
    logic [11:0] prev_paddr;
    logic        prev_pwrite;
    logic [31:0] prev_pwdata;
    assign psel = {PSEL3, PSEL2, PSEL1, PSEL0};

    always @(negedge PCLK) begin
        if (PRESET) begin
            prev_psel <= 4'b0;
        end else begin
            chk("psel_onehot", 32'($countones(psel) <= 1), 32'd1);
            if (psel != 4'b0) begin
                chk("psel_slot", {28'd0, psel}, {28'd0, exp_psel});
                chk("paddr", {20'd0, PADDR}, {20'd0, exp_paddr});
                chk("pwrite", {31'd0, PWRITE}, {31'd0, exp_pwrite});
                if (exp_pwrite) chk("pwdata", PWDATA, exp_pwdata);
                if (prev_psel == 4'b0) chk("setup_penable", {31'd0, PENABLE}, 32'd0);
                else begin
                    chk("paddr_stable", {20'd0, PADDR}, {20'd0, prev_paddr});
                    chk("pwdata_stable", PWDATA, prev_pwdata);
                    chk("pwrite_stable", {31'd0, PWRITE}, {31'd0, prev_pwrite});
                end
            end
            if (PENABLE) chk("penable_after_psel", {28'd0, prev_psel}, {28'd0, psel});
            prev_psel   <= psel;
            prev_paddr  <= PADDR;
            prev_pwrite <= PWRITE;
            prev_pwdata <= PWDATA;
        end
    end

    // Issue one request in the current cycle (caller is just past a posedge, bridge IDLE),
    // return in the cycle where ready is observed so the next request can go back-to-back.
    task automatic run_xfer(input bit wr, input bit [31:0] a, input bit [31:0] d, input int w,
                            input bit noise);
        int          slot;
        bit          hit;
        int          lat;
        bit          e_err;
        bit [31:0]   e_rd;
        int          k;
        slot  = int'((a >> 12) & 32'hF);
        hit   = (a[31:16] == 16'h1000) && (slot < 4);
        e_err = 1'b0;
        e_rd  = 32'd0;
        if (!hit) begin
            lat = 1; e_err = 1'b1; exp_psel = 4'b0;
        end else begin
            exp_psel = 4'(1 << slot);
            case (slot)
                0: lat = 4;
                1: if (w < 16) lat = 3 + w; else begin lat = 18; e_err = 1'b1; end
                default: lat = 3;
            endcase
            if (!e_err) begin
                if (wr) begin
                    if (slot == 0) ram0_m[a[11:2]] = d;
                    if (slot == 1) mem1_m[a[5:2]] = d;
                end else begin
                    case (slot)
                        0: e_rd = ram0_m[a[11:2]];
                        1: e_rd = mem1_m[a[5:2]];
                        default: e_rd = 32'hA000_0000 + (32'(slot) << 24) + {20'd0, a[11:0]};
                    endcase
                end
            end
        end
        exp_paddr  = a[11:0];
        exp_pwrite = wr;
        exp_pwdata = d;
        wait1      = w;
        write      = wr;
        addr       = a;
        wdata      = d;
        transfer   = 1'b1;
        k = 0;
        while (k < 40) begin
            @(posedge PCLK); #1;
            k++;
            if (ready) begin
                transfer = 1'b0;
                break;
            end
            if (noise) begin
                transfer = 1'($urandom);
                write    = 1'($urandom);
                addr     = $urandom;
                wdata    = $urandom;
            end else begin
                transfer = 1'b0;
            end
        end
        transfer = 1'b0;
        chk("latency", 32'(k), 32'(lat));
        chk("err", {31'd0, err}, {31'd0, e_err});
        chk("rdata", rdata, e_rd);
        $display("xfer %s addr=%h wdata=%h wait=%0d -> cycles=%0d err=%0b rdata=%h",
                 wr ? "WR" : "RD", a, d, w, k, err, rdata);
    endtask

    initial begin
        bit [31:0] a;
        int        cat;
        int        w;
        for (int i = 0; i < 1024; i++) begin ram0[i] = 32'd0; ram0_m[i] = 32'd0; end
        for (int i = 0; i < 16; i++)   begin mem1[i] = 32'd0; mem1_m[i] = 32'd0; end
        PRESET = 1'b1; transfer = 1'b0; write = 1'b0; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_psel", {28'd0, psel}, 32'd0);
        chk("rst_penable", {31'd0, PENABLE}, 32'd0);
        chk("rst_paddr", {20'd0, PADDR}, 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_pwrite", {31'd0, PWRITE}, 32'd0);
        PRESET = 1'b0;
        @(posedge PCLK); #1;

        // Directed cases
        run_xfer(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 0, 1'b0);
        @(posedge PCLK); #1;
        run_xfer(1'b0, 32'h1000_0010, 32'd0, 0, 1'b0);
        @(posedge PCLK); #1;
        run_xfer(1'b0, 32'h2000_0000, 32'd0, 0, 1'b0);
        @(posedge PCLK); #1;
        run_xfer(1'b0, 32'h1000_1000, 32'd0, 255, 1'b0);
        run_xfer(1'b1, 32'h1000_1008, 32'h1234_5678, 15, 1'b0);
        run_xfer(1'b0, 32'h1000_1008, 32'd0, 16, 1'b0);
        run_xfer(1'b0, 32'h1000_1008, 32'd0, 15, 1'b0);
        // Back-to-back on the RAM: stale PREADY falls in the accepting IDLE cycle
        run_xfer(1'b1, 32'h1000_0020, 32'hCAFE_F00D, 0, 1'b1);
        run_xfer(1'b0, 32'h1000_0020, 32'd0, 0, 1'b1);
        run_xfer(1'b0, 32'h1000_0010, 32'd0, 0, 1'b0);
        run_xfer(1'b0, 32'h1000_4000, 32'd0, 0, 1'b0);
        run_xfer(1'b0, 32'h1000_3abc, 32'd0, 0, 1'b0);

        // Reset while waiting in ACCESS
        exp_psel = 4'b0010; exp_paddr = 12'h004; exp_pwrite = 1'b0; exp_pwdata = 32'd0;
        wait1 = 255; write = 1'b0; addr = 32'h1000_1004; wdata = 32'd0; transfer = 1'b1;
        @(posedge PCLK); #1; transfer = 1'b0;
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        chk("pre_rst_access", {31'd0, PENABLE}, 32'd1);
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        chk("mid_rst_psel", {28'd0, psel}, 32'd0);
        chk("mid_rst_penable", {31'd0, PENABLE}, 32'd0);
        chk("mid_rst_ready", {31'd0, ready}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        chk("mid_rst_paddr", {20'd0, PADDR}, 32'd0);
        chk("mid_rst_pwrite", {31'd0, PWRITE}, 32'd0);
        chk("mid_rst_pwdata", PWDATA, 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(posedge PCLK); #1;
            chk("no_ready_after_rst", {31'd0, ready}, 32'd0);
        end
        run_xfer(1'b0, 32'h1000_0020, 32'd0, 0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            cat = $urandom_range(0, 9);
            if (cat < 8) begin
                a = 32'h1000_0000 + ($urandom_range(0, 3) << 12) + ($urandom_range(0, 15) << 2);
            end else if (cat == 8) begin
                a = $urandom;
                if (a[31:16] == 16'h1000) a[31] = 1'b1;
            end else begin
                a = 32'h1000_0000 | ($urandom_range(4, 15) << 12) | $urandom_range(0, 4095);
            end
            w = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 30) : $urandom_range(0, 15);
            run_xfer(1'($urandom), a, $urandom, w, 1'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge PCLK); #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
